// File: rtl/vga_timing_gen_if.sv
// Pixel-side bus of the VGA timing generator: colour in from the mapper,
// scan position, frame strobe and registered DAC pins out.
interface vga_timing_gen_if;
    logic [7:0]  R_in;
    logic [7:0]  G_in;
    logic [7:0]  B_in;
    logic        pixel_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        input  R_in, G_in, B_in,
        output pixel_clk, DrawX, DrawY, hs, vs, blank,
               VGA_R, VGA_G, VGA_B, frame_start, frame_count
    );

    modport slave (
        output R_in, G_in, B_in,
        input  pixel_clk, DrawX, DrawY, hs, vs, blank,
               VGA_R, VGA_G, VGA_B, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing from the system clock at half rate: scan counters,
// sync/blank decode and a registered colour stage one pixel behind the counters.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic              Clk,
    input  logic              Reset,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic        tick;
    logic [9:0]  hc_p0;
    logic [9:0]  vc_p0;
    logic        hs_p1;
    logic        vs_p1;
    logic        blank_p1;
    logic [7:0]  r_p1;
    logic [7:0]  g_p1;
    logic [7:0]  b_p1;
    logic        frame_start_p1;
    logic [15:0] frame_count_p1;

    logic h_wrap;
    logic v_wrap;
    logic visible;
    logic hsync_region;
    logic vsync_region;

    // Stage p0 decode: every region test uses the pre-increment position.
    assign h_wrap       = (hc_p0 == H_LAST);
    assign v_wrap       = (vc_p0 == V_LAST);
    assign visible      = (hc_p0 < H_VIS) && (vc_p0 < V_VIS);
    assign hsync_region = (hc_p0 >= HS_FIRST) && (hc_p0 <= HS_LAST);
    assign vsync_region = (vc_p0 >= VS_FIRST) && (vc_p0 <= VS_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick           <= 1'b0;
            hc_p0          <= '0;
            vc_p0          <= '0;
            hs_p1          <= 1'b1;
            vs_p1          <= 1'b1;
            blank_p1       <= 1'b0;
            r_p1           <= '0;
            g_p1           <= '0;
            b_p1           <= '0;
            frame_start_p1 <= 1'b0;
            frame_count_p1 <= '0;
        end else begin
            tick           <= ~tick;
            // The strobe lasts one Clk: the edge after an advance edge never advances.
            frame_start_p1 <= 1'b0;
            if (tick) begin
                hc_p0 <= h_wrap ? 10'd0 : hc_p0 + 10'd1;
                if (h_wrap) begin
                    vc_p0 <= v_wrap ? 10'd0 : vc_p0 + 10'd1;
                    if (v_wrap) begin
                        frame_start_p1 <= 1'b1;
                        frame_count_p1 <= frame_count_p1 + 16'd1;
                    end
                end
                // Stage p1: pin outputs for the pixel the counters held before this edge.
                hs_p1    <= ~hsync_region;
                vs_p1    <= ~vsync_region;
                blank_p1 <= visible;
                r_p1     <= visible ? vga.R_in : 8'd0;
                g_p1     <= visible ? vga.G_in : 8'd0;
                b_p1     <= visible ? vga.B_in : 8'd0;
            end
        end
    end

    assign vga.pixel_clk   = tick;
    assign vga.DrawX       = hc_p0;
    assign vga.DrawY       = vc_p0;
    assign vga.hs          = hs_p1;
    assign vga.vs          = vs_p1;
    assign vga.blank       = blank_p1;
    assign vga.VGA_R       = r_p1;
    assign vga.VGA_G       = g_p1;
    assign vga.VGA_B       = b_p1;
    assign vga.frame_start = frame_start_p1;
    assign vga.frame_count = frame_count_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster: a driver predicts
// each pixel's pin outputs from its raster index, a monitor checks them.
module tb_vga_timing_gen;
    localparam int HV  = 8;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HB  = 2;
    localparam int VV  = 4;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 1;
    localparam int HT  = HV + HF + HSW + HB;
    localparam int VT  = VV + VF + VSW + VB;
    localparam int FP  = HT * VT;

    typedef struct {
        int          xn;
        int          yn;
        bit          hs;
        bit          vs;
        bit          blank;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        bit          fs;
        logic [15:0] fc;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .vga   (vif)
    );

    always #5 Clk = ~Clk;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          n = 0;
    logic [15:0] fc_m = '0;
    bit          solid = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pixel_clk"}, vif.pixel_clk, 0);
        chk({tag, "_DrawX"}, vif.DrawX, 0);
        chk({tag, "_DrawY"}, vif.DrawY, 0);
        chk({tag, "_hs"}, vif.hs, 1);
        chk({tag, "_vs"}, vif.vs, 1);
        chk({tag, "_blank"}, vif.blank, 0);
        chk({tag, "_rgb"}, {8'd0, vif.VGA_R, vif.VGA_G, vif.VGA_B}, 0);
        chk({tag, "_frame_start"}, vif.frame_start, 0);
        chk({tag, "_frame_count"}, vif.frame_count, 0);
    endtask

    // Drive one colour per pixel while it sits on DrawX/DrawY and queue what the
    // pins must show after that pixel's advance edge.
    task automatic run_pixels(input int count);
        for (int k = 0; k < count; k++) begin
            exp_t e;
            int x, y;
            bit got;
            logic [7:0] r, g, b;
            x = n % HT;
            y = (n / HT) % VT;
            r = solid ? 8'hFF : 8'($urandom);
            g = solid ? 8'hFF : 8'($urandom);
            b = solid ? 8'hFF : 8'($urandom);
            vif.R_in = r;
            vif.G_in = g;
            vif.B_in = b;
            e.blank = (x < HV) && (y < VV);
            e.hs    = !((x >= HV + HF) && (x < HV + HF + HSW));
            e.vs    = !((y >= VV + VF) && (y < VV + VF + VSW));
            e.r     = e.blank ? r : 8'd0;
            e.g     = e.blank ? g : 8'd0;
            e.b     = e.blank ? b : 8'd0;
            e.fs    = (x == HT - 1) && (y == VT - 1);
            if (e.fs) fc_m = fc_m + 16'd1;
            e.fc    = fc_m;
            e.xn    = (n + 1) % HT;
            e.yn    = ((n + 1) / HT) % VT;
            exp_q.push_back(e);
            got = 1'b0;
            for (int w = 0; w < 4 && !got; w++) begin
                @(posedge Clk);
                #2;
                if (vif.pixel_clk === 1'b0) got = 1'b1;
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL advance_timeout actual=no_advance required=advance_within_4_clk at %0t", $time);
            end
            n++;
        end
    endtask

    // Monitor: compares on every advance edge, plus per-Clk strobe/period checks.
    initial begin
        bit prev_pc;
        bit seen_fs;
        int cyc, last_fs, vs_low;
        exp_t e;
        prev_pc = 1'b0; seen_fs = 1'b0; cyc = 0; last_fs = 0; vs_low = 0;
        forever begin
            @(posedge Clk);
            #1;
            if (Reset) begin
                prev_pc = 1'b0; seen_fs = 1'b0; cyc = 0; vs_low = 0;
            end else begin
                cyc++;
                if (vif.vs === 1'b0) vs_low++;
                chk("pixel_clk_toggle", vif.pixel_clk, !prev_pc);
                if (prev_pc) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_empty actual=0_entries required=1_entry at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("DrawX", vif.DrawX, e.xn);
                        chk("DrawY", vif.DrawY, e.yn);
                        chk("hs", vif.hs, e.hs);
                        chk("vs", vif.vs, e.vs);
                        chk("blank", vif.blank, e.blank);
                        chk("VGA_R", vif.VGA_R, e.r);
                        chk("VGA_G", vif.VGA_G, e.g);
                        chk("VGA_B", vif.VGA_B, e.b);
                        chk("frame_start", vif.frame_start, e.fs);
                        chk("frame_count", vif.frame_count, e.fc);
                    end
                end else begin
                    chk("frame_start_idle", vif.frame_start, 0);
                end
                if (vif.frame_start === 1'b1) begin
                    // First pulse after release lands on advance edge FP, i.e. Clk 2*FP.
                    chk("frame_period", seen_fs ? cyc - last_fs : cyc, 2 * FP);
                    chk("vs_low_clks", vs_low, 2 * VSW * HT);
                    seen_fs = 1'b1;
                    last_fs = cyc;
                    vs_low = 0;
                end
                prev_pc = vif.pixel_clk;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vif.R_in = '0;
        vif.G_in = '0;
        vif.B_in = '0;
        Reset = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        check_reset("rst_init");
        @(negedge Clk);
        Reset = 1'b0;

        run_pixels(FP);
        solid = 1'b0;
        run_pixels(FP + FP / 2);

        force dut.frame_count_p1 = 16'hFFFF;
        #1;
        release dut.frame_count_p1;
        fc_m = 16'hFFFF;
        run_pixels(FP);

        run_pixels($urandom_range(FP / 4, FP - 1));
        #1 Reset = 1'b1;
        #1 check_reset("rst_mid");
        exp_q.delete();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        n = 0;
        fc_m = '0;
        run_pixels(2 * FP + 5);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
